// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default geometry for the cache-line to pmem burst adaptor.
package cacheline_pkg;
   localparam int CACHE_LINE_WIDTH = 256;
   localparam int BURST_LEN        = 4;
   localparam int BURST_WIDTH      = CACHE_LINE_WIDTH / BURST_LEN;
   localparam int ADDR_WIDTH       = 32;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
   typedef logic [CACHE_LINE_WIDTH-1:0] line_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and pmem-side signals of the adaptor; master is the adaptor, slave is its environment.
interface cacheline_adaptor_if
   import cacheline_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = cacheline_pkg::CACHE_LINE_WIDTH,
   parameter int BURST_LEN        = cacheline_pkg::BURST_LEN,
   parameter int ADDR_WIDTH       = cacheline_pkg::ADDR_WIDTH
);
   localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;

   logic [CACHE_LINE_WIDTH-1:0] line_i;
   logic [CACHE_LINE_WIDTH-1:0] line_o;
   logic [ADDR_WIDTH-1:0]       address_i;
   logic                        read_i;
   logic                        write_i;
   logic                        resp_o;
   logic [BURST_WIDTH-1:0]      burst_i;
   logic [BURST_WIDTH-1:0]      burst_o;
   logic [ADDR_WIDTH-1:0]       address_o;
   logic                        read_o;
   logic                        write_o;
   logic                        resp_i;

   modport master (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport slave (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/cacheline_adaptor_burst_shifter.sv
// Line buffer and beat counter: serialises a loaded line into beats, or assembles beats into a line.
module burst_shifter
   import cacheline_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = cacheline_pkg::CACHE_LINE_WIDTH,
   parameter int BURST_LEN        = cacheline_pkg::BURST_LEN
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   load,
   input  logic                                   clear,
   input  logic                                   shift,
   input  logic                                   capture,
   input  logic [CACHE_LINE_WIDTH-1:0]            line_in,
   input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]  beat_in,
   output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0]  beat_out,
   output logic [CACHE_LINE_WIDTH-1:0]            line_out,
   output logic                                   last
);
   localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
   localparam int CNT_WIDTH   = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

   logic [CACHE_LINE_WIDTH-1:0] buffer;
   logic [CACHE_LINE_WIDTH-1:0] buffer_next;
   logic [CNT_WIDTH-1:0]        cnt;

   assign last = (cnt == LAST_BEAT);

   always_comb begin
      buffer_next = buffer;
      beat_out    = '0;
      for (int b = 0; b < BURST_LEN; b++) begin
         if (cnt == CNT_WIDTH'(b)) begin
            beat_out = buffer[b*BURST_WIDTH +: BURST_WIDTH];
            if (shift && capture) begin
               buffer_next[b*BURST_WIDTH +: BURST_WIDTH] = beat_in;
            end
         end
      end
      if (load) begin
         buffer_next = line_in;
      end
   end

   // line_out is published together with the final beat so it is valid during the completion cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         buffer   <= '0;
         cnt      <= '0;
         line_out <= '0;
      end else begin
         buffer <= buffer_next;
         if (load || clear) begin
            cnt <= '0;
         end else if (shift) begin
            cnt <= cnt + 1'b1;
         end
         if (shift && capture && last) begin
            line_out <= buffer_next;
         end
      end
   end
endmodule

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write request into a BURST_LEN-beat pmem burst, then pulses resp_o for one cycle.
module cacheline_adaptor
   import cacheline_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = cacheline_pkg::CACHE_LINE_WIDTH,
   parameter int BURST_LEN        = cacheline_pkg::BURST_LEN,
   parameter int ADDR_WIDTH       = cacheline_pkg::ADDR_WIDTH
) (
   input logic                 clk,
   input logic                 rst,
   cacheline_adaptor_if.master bus
);
   localparam int BURST_WIDTH = CACHE_LINE_WIDTH / BURST_LEN;
   localparam int OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

   adaptor_state_t          state;
   adaptor_state_t          state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    load;
   logic                    clear;
   logic                    shift;
   logic                    capture;
   logic                    last;
   logic [BURST_WIDTH-1:0]  beat_out;
   logic [CACHE_LINE_WIDTH-1:0] line_out;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         addr_q <= '0;
      end else begin
         state <= state_next;
         if (load || clear) begin
            addr_q <= bus.address_i & ALIGN_MASK;
         end
      end
   end

   // Simultaneous read and write requests are ambiguous and left pending in IDLE
   always_comb begin
      state_next = state;
      load       = 1'b0;
      clear      = 1'b0;
      shift      = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.read_i && !bus.write_i) begin
               clear      = 1'b1;
               state_next = READ;
            end else if (bus.write_i && !bus.read_i) begin
               load       = 1'b1;
               state_next = WRITE;
            end
         end
         READ: begin
            capture = 1'b1;
            shift   = bus.resp_i;
            if (bus.resp_i && last) state_next = DONE;
         end
         WRITE: begin
            shift = bus.resp_i;
            if (bus.resp_i && last) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   burst_shifter #(
      .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH),
      .BURST_LEN        (BURST_LEN)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .clear    (clear),
      .shift    (shift),
      .capture  (capture),
      .line_in  (bus.line_i),
      .beat_in  (bus.burst_i),
      .beat_out (beat_out),
      .line_out (line_out),
      .last     (last)
   );

   assign bus.read_o    = (state == READ);
   assign bus.write_o   = (state == WRITE);
   assign bus.resp_o    = (state == DONE);
   assign bus.address_o = addr_q;
   assign bus.burst_o   = beat_out;
   assign bus.line_o    = line_out;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: transaction table, pmem model and a completion scoreboard.
module tb_cacheline_adaptor;
   import cacheline_pkg::*;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      int          delay;
      line_t       line;
   } vec_t;

   typedef struct {
      bit          is_read;
      logic [31:0] addr;
      line_t       line;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cacheline_adaptor_if bus ();

   cacheline_adaptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    n_vec = 0;
   int    n_err = 0;
   int    resp_cnt = 0;
   sb_t   sb[$];
   line_t mem [bit [31:0]];
   line_t last_read = '0;
   vec_t  tbl [5];

   localparam line_t L_READ  = {64'h4444444444444444, 64'h3333333333333333,
                                64'h2222222222222222, 64'h1111111111111111};
   localparam line_t L_WRITE = {64'hDEADDEAD00000003, 64'hDEADDEAD00000002,
                                64'hBEEFBEEF00000001, 64'hBEEFBEEF00000000};
   localparam line_t L_W2    = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                64'hA5A5A5A55A5A5A5A, 64'h00FF00FF00FF00FF};
   localparam line_t L_OVL   = {64'hC0C0C0C0C0C0C0C0, 64'hB0B0B0B0B0B0B0B0,
                                64'hA0A0A0A0A0A0A0A0, 64'h9090909090909090};
   localparam line_t L_RST   = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C,
                                64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Completion monitor: every resp_o pulse must match a queued expectation
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (bus.resp_o === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_resp: got resp_o=1 expected no completion at %0t", $time);
            end else begin
               e = sb.pop_front();
               if (e.is_read) chk("line_o", bus.line_o, e.line);
               else           chk("mem_line", mem[e.addr], e.line);
            end
         end
      end
   end

   task automatic serve_read(input logic [31:0] addr, input int delay);
      logic [31:0] a = addr & ~32'h1F;
      line_t m = mem[a];
      for (int d = 0; d < delay; d++) begin
         chk("rd_read_o", bus.read_o, 1'b1);
         chk("rd_write_o", bus.write_o, 1'b0);
         chk("rd_addr", bus.address_o, a);
         chk("rd_resp_early", bus.resp_o, 1'b0);
         bus.address_i = $urandom;
         @(posedge clk); #1;
      end
      for (int b = 0; b < BURST_LEN; b++) begin
         chk("rd_beat_read_o", bus.read_o, 1'b1);
         chk("rd_beat_addr", bus.address_o, a);
         chk("rd_beat_resp", bus.resp_o, 1'b0);
         bus.resp_i  = 1'b1;
         bus.burst_i = m[b*BURST_WIDTH +: BURST_WIDTH];
         @(posedge clk); #1;
         bus.resp_i  = 1'b0;
         bus.burst_i = {$urandom, $urandom};
      end
      chk("rd_done_resp", bus.resp_o, 1'b1);
      chk("rd_done_read_o", bus.read_o, 1'b0);
      chk("rd_done_write_o", bus.write_o, 1'b0);
      bus.read_i = 1'b0;
      @(posedge clk); #1;
      chk("rd_resp_one_cycle", bus.resp_o, 1'b0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int delay, input line_t exp);
      sb.push_back('{1'b1, addr & ~32'h1F, exp});
      bus.address_i = addr;
      bus.read_i    = 1'b1;
      bus.write_i   = 1'b0;
      @(posedge clk); #1;
      serve_read(addr, delay);
      last_read = exp;
   endtask

   task automatic do_write(input logic [31:0] addr, input int delay, input line_t line);
      logic [31:0] a = addr & ~32'h1F;
      line_t got = '0;
      sb.push_back('{1'b0, a, line});
      bus.address_i = addr;
      bus.line_i    = line;
      bus.write_i   = 1'b1;
      bus.read_i    = 1'b0;
      @(posedge clk); #1;
      bus.line_i = ~line;
      for (int d = 0; d < delay; d++) begin
         chk("wr_write_o", bus.write_o, 1'b1);
         chk("wr_read_o", bus.read_o, 1'b0);
         chk("wr_addr", bus.address_o, a);
         chk("wr_beat0_early", bus.burst_o, line[BURST_WIDTH-1:0]);
         bus.address_i = $urandom;
         @(posedge clk); #1;
      end
      for (int b = 0; b < BURST_LEN; b++) begin
         chk("wr_beat_write_o", bus.write_o, 1'b1);
         chk("wr_beat_read_o", bus.read_o, 1'b0);
         chk("wr_beat_addr", bus.address_o, a);
         chk("wr_burst_o", bus.burst_o, line[b*BURST_WIDTH +: BURST_WIDTH]);
         got[b*BURST_WIDTH +: BURST_WIDTH] = bus.burst_o;
         bus.resp_i = 1'b1;
         @(posedge clk); #1;
         bus.resp_i = 1'b0;
      end
      mem[a] = got;
      chk("wr_done_resp", bus.resp_o, 1'b1);
      chk("wr_done_write_o", bus.write_o, 1'b0);
      chk("wr_line_o_hold", bus.line_o, last_read);
      bus.write_i = 1'b0;
      @(posedge clk); #1;
      chk("wr_resp_one_cycle", bus.resp_o, 1'b0);
   endtask

   initial begin
      int base;
      bus.line_i = '0;  bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
      bus.burst_i = '0; bus.resp_i = 1'b0;

      tbl[0] = '{1'b0, 32'h0000_0064, 10, L_READ};
      tbl[1] = '{1'b1, 32'h1000_001F, 3,  L_WRITE};
      tbl[2] = '{1'b0, 32'h1000_0008, 2,  L_WRITE};
      tbl[3] = '{1'b1, 32'h0000_0480, 0,  L_W2};
      tbl[4] = '{1'b0, 32'h0000_049C, 1,  L_W2};
      mem[32'h0000_0060] = L_READ;
      mem[32'h0000_0200] = L_OVL;
      mem[32'h0000_0300] = L_RST;

      // Reset state, with requests asserted to prove reset dominates
      bus.read_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_read_o", bus.read_o, 1'b0);
      chk("rst_write_o", bus.write_o, 1'b0);
      chk("rst_resp_o", bus.resp_o, 1'b0);
      chk("rst_address_o", bus.address_o, 32'h0);
      chk("rst_burst_o", bus.burst_o, 64'h0);
      chk("rst_line_o", bus.line_o, 256'h0);
      bus.read_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         if (i == 1) base = resp_cnt;
         if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].delay, tbl[i].line);
         else           do_read(tbl[i].addr, tbl[i].delay, tbl[i].line);
         if (i == 2) chk("b2b_resp_count", resp_cnt - base, 2);
      end

      // Overlapping read+write requests are ignored until write_i drops
      sb.push_back('{1'b1, 32'h0000_0200, L_OVL});
      bus.address_i = 32'h0000_0210;
      bus.read_i = 1'b1;
      bus.write_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("ovl_read_o", bus.read_o, 1'b0);
         chk("ovl_write_o", bus.write_o, 1'b0);
      end
      bus.write_i = 1'b0;
      @(posedge clk); #1;
      chk("ovl_start", bus.read_o, 1'b1);
      serve_read(32'h0000_0210, 1);
      last_read = L_OVL;

      // Reset during beat 2 of a read aborts it without a completion
      base = resp_cnt;
      bus.address_i = 32'h0000_0300;
      bus.read_i = 1'b1;
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++) begin
         bus.resp_i  = 1'b1;
         bus.burst_i = L_RST[b*BURST_WIDTH +: BURST_WIDTH];
         @(posedge clk); #1;
      end
      bus.burst_i = L_RST[2*BURST_WIDTH +: BURST_WIDTH];
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_read_o", bus.read_o, 1'b0);
      chk("abort_resp_o", bus.resp_o, 1'b0);
      chk("abort_address_o", bus.address_o, 32'h0);
      chk("abort_line_o", bus.line_o, 256'h0);
      rst = 1'b1;
      bus.resp_i = 1'b0;
      bus.read_i = 1'b0;
      last_read = '0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_idle_read_o", bus.read_o, 1'b0);
      end
      chk("abort_no_resp", resp_cnt - base, 0);
      do_read(32'h0000_0300, 0, L_RST);

      // Stray resp_i in IDLE has no effect
      bus.resp_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk("idle_resp_read_o", bus.read_o, 1'b0);
         chk("idle_resp_write_o", bus.write_o, 1'b0);
         chk("idle_resp_resp_o", bus.resp_o, 1'b0);
      end
      bus.resp_i = 1'b0;
      do_read(32'h0000_0064, 4, L_READ);

      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
